stoch_bitstream_decoder: RTL and testbench
==========================================

STOCH_BITSTREAM_DECODER -- requirements
Module: stoch_bitstream_decoder

Interface
REQ-001 The module SHALL have parameter WINDOW_LOG2, default 8, giving log2 of the number of enabled cycles averaged per estimate (legal range 2..16).
REQ-002 The module SHALL have parameter WARMUP_CYCLES, default 16, giving the number of enabled cycles discarded after reset or clear (legal range 0..65535).
REQ-003 The module SHALL have port CLK  input  1  as the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port nRST  input  1  as the reset; it is asynchronous and active-low.
REQ-005 The module SHALL have port en  input  1  as the sample enable; a is sampled only in cycles where en=1.
REQ-006 The module SHALL have port a  input  1  as the unipolar stochastic bitstream, typically the y output of the stochastic square-root stage.
REQ-007 The module SHALL have port clear  input  1  as a synchronous restart of warmup and accumulation.
REQ-008 The module SHALL have port y  output  WINDOW_LOG2  as the registered unsigned estimate of P(a=1), scaled so that full scale equals 2^WINDOW_LOG2.
REQ-009 The module SHALL have port y_valid  output  1  to indicate that y holds an unconsumed estimate.
REQ-010 The module SHALL have port y_ready  input  1  as the consumer accept; a transfer occurs in any cycle with y_valid=1 and y_ready=1.
REQ-011 The module SHALL have port overrun  output  1  as a sticky flag indicating that an unconsumed estimate was overwritten.

Function
REQ-012 The control FSM SHALL have exactly two states, WARMUP and ACCUM.
REQ-013 In WARMUP, each en=1 cycle SHALL increment a warmup counter, and a SHALL be ignored.
REQ-014 The FSM SHALL move from WARMUP to ACCUM on the en=1 cycle that completes the WARMUP_CYCLES-th sample; when WARMUP_CYCLES=0, it SHALL enter ACCUM directly from reset or clear.
REQ-015 In ACCUM, each en=1 cycle SHALL increment the window counter and SHALL add a to a ones accumulator of width WINDOW_LOG2+1.
REQ-016 Cycles with en=0 SHALL leave all counters, the accumulator, and the FSM state unchanged.
REQ-017 A window SHALL complete on the en=1 cycle that supplies the 2^WINDOW_LOG2-th sample, and that sample SHALL be included in the count.
REQ-018 On window completion, the final count including the current sample SHALL be loaded into y on the same clock edge, and y_valid SHALL be set, giving a latency of 1 clock from the last sample.
REQ-019 The count SHALL saturate: a full-window count of 2^WINDOW_LOG2 SHALL produce y = 2^WINDOW_LOG2 - 1, and every other count SHALL pass through unchanged.
REQ-020 On window completion, the window counter and accumulator SHALL restart from zero, and ACCUM SHALL continue with no gap cycle; warmup SHALL NOT repeat.
REQ-021 y SHALL change only on window completion, reset, or clear, and SHALL remain stable while y_valid=1 and y_ready=0 unless a new window completes.
REQ-022 On a transfer, y_valid SHALL clear on the next edge if no window completes in that same cycle.
REQ-023 If a window completes in the same cycle as a transfer, the new y SHALL be loaded, y_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-024 If a window completes while y_valid=1 and y_ready=0, the new y SHALL overwrite the old value, y_valid SHALL stay 1, and overrun SHALL be set.
REQ-025 Once set, overrun SHALL remain set until reset or clear.
REQ-026 clear=1 SHALL, on the next edge, force state WARMUP (or ACCUM if WARMUP_CYCLES=0), zero all counters and the accumulator, set y_valid=0 and overrun=0, and set y=0.
REQ-027 clear SHALL take priority over en, window completion, and transfer in the same cycle.
REQ-028 y_ready SHALL have no effect while y_valid=0.
REQ-029 Outputs SHALL have no combinational path from a, en, or y_ready.

Reset
REQ-030 While nRST=0, the module SHALL asynchronously force y=0, y_valid=0, overrun=0, all counters and the accumulator to 0, and state WARMUP (or ACCUM if WARMUP_CYCLES=0).
REQ-031 Assertion of nRST mid-window SHALL discard the partial count, and the first estimate after release SHALL come only after a full warmup plus a full window.
REQ-032 The first rising CLK edge after nRST deasserts SHALL be treated as an ordinary operating edge.

Verification
REQ-033 The bench SHALL cover: WINDOW_LOG2=4, WARMUP_CYCLES=2, en=1, a=1 constant, y_ready=1 -> first y_valid at cycle 19 after reset release with y=15 (saturated); a new estimate every 16 cycles thereafter.
REQ-034 The bench SHALL cover: same configuration, a pattern 1010... -> y=8 on each window, with overrun staying 0.
REQ-035 The bench SHALL cover: en toggling 1/0 every cycle with a=1 on enabled cycles -> window period of 32 clocks and y=15.
REQ-036 The bench SHALL cover: y_ready=0 across two window completions -> y updated to the second estimate, y_valid=1, overrun=1; then y_ready=1 for one cycle -> y_valid=0 and overrun still 1.
REQ-037 The bench SHALL cover: y_ready=1 in exactly the completion cycle of the next window -> y updated, y_valid stays 1, overrun=0.
REQ-038 The bench SHALL cover: clear pulsed mid-window with y_valid=1, and separately nRST pulsed mid-window -> y=0, y_valid=0, overrun=0, and the next estimate after 2+16 enabled cycles, counting only the new samples.

Source files
------------

// File: rtl/stoch_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// stoch_bitstream_decoder
// Converts a unipolar stochastic bitstream back into a binary estimate of
// P(a=1). After a warmup of WARMUP_CYCLES enabled samples, the block counts
// ones over back-to-back windows of 2^WINDOW_LOG2 enabled samples. Each window
// produces one registered, saturated estimate with a valid/ready handshake.
//
// Ports
//   CLK      in   clock, rising edge
//   nRST     in   asynchronous active-low reset
//   en       in   sample enable; a is only looked at when en=1
//   a        in   stochastic bitstream
//   clear    in   synchronous restart of warmup and accumulation
//   y        out  estimate, full scale 2^WINDOW_LOG2 (saturated to all ones)
//   y_valid  out  y holds an estimate not yet accepted
//   y_ready  in   consumer accept
//   overrun  out  sticky: an unaccepted estimate was overwritten
// -----------------------------------------------------------------------------
module stoch_bitstream_decoder #(
   parameter int WINDOW_LOG2   = 8,
   parameter int WARMUP_CYCLES = 16
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   en,
   input  logic                   a,
   input  logic                   clear,
   output logic [WINDOW_LOG2-1:0] y,
   output logic                   y_valid,
   input  logic                   y_ready,
   output logic                   overrun
);

   typedef enum logic {
      ST_WARMUP = 1'b0,
      ST_ACCUM  = 1'b1
   } state_t;

   // With no warmup requested the block starts straight in ACCUM.
   localparam state_t      ST_INIT   = state_t'((WARMUP_CYCLES == 0) ? 1'b1 : 1'b0);
   localparam logic [15:0] WARM_LAST = (WARMUP_CYCLES == 0) ? 16'd0 : 16'(WARMUP_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [15:0]            r_warm_cnt;
   logic [WINDOW_LOG2-1:0] r_win_cnt;
   logic [WINDOW_LOG2:0]   r_acc;
   logic [WINDOW_LOG2:0]   w_count;
   logic [WINDOW_LOG2-1:0] w_sat;
   logic                   w_win_done;
   logic [WINDOW_LOG2-1:0] r_y;
   logic                   r_valid;
   logic                   r_ovr;

   assign y       = r_y;
   assign y_valid = r_valid;
   assign overrun = r_ovr;

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and window-completion detect.
   always_comb begin
      w_state_nxt = r_state;
      w_win_done  = 1'b0;
      case (r_state)
         ST_WARMUP: begin
            if (en && (r_warm_cnt == WARM_LAST)) begin
               w_state_nxt = ST_ACCUM;
            end else begin
               w_state_nxt = ST_WARMUP;
            end
         end
         ST_ACCUM: begin
            w_state_nxt = ST_ACCUM;
            // The last sample of the window is the one arriving while the
            // window counter is at all ones.
            if (en && (r_win_cnt == {WINDOW_LOG2{1'b1}})) begin
               w_win_done = 1'b1;
            end else begin
               w_win_done = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
      if (clear) begin
         w_state_nxt = ST_INIT;
      end else begin
         w_state_nxt = w_state_nxt;
      end
   end

   // Count including the current sample, and its saturated form for y.
   always_comb begin
      w_count = r_acc + {{WINDOW_LOG2{1'b0}}, a};
      if (w_count[WINDOW_LOG2]) begin
         w_sat = {WINDOW_LOG2{1'b1}};
      end else begin
         w_sat = w_count[WINDOW_LOG2-1:0];
      end
   end

   // Warmup counter, window counter and ones accumulator.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_warm_cnt <= 16'd0;
         r_win_cnt  <= {WINDOW_LOG2{1'b0}};
         r_acc      <= {(WINDOW_LOG2 + 1){1'b0}};
      end else if (clear) begin
         r_warm_cnt <= 16'd0;
         r_win_cnt  <= {WINDOW_LOG2{1'b0}};
         r_acc      <= {(WINDOW_LOG2 + 1){1'b0}};
      end else if (en) begin
         if (r_state == ST_WARMUP) begin
            r_warm_cnt <= r_warm_cnt + 16'd1;
         end else begin
            // Window counter wraps to zero on its own at completion.
            r_win_cnt <= r_win_cnt + WINDOW_LOG2'(1);
            if (w_win_done) begin
               r_acc <= {(WINDOW_LOG2 + 1){1'b0}};
            end else begin
               r_acc <= w_count;
            end
         end
      end
   end

   // Output estimate, valid/ready handshake and sticky overrun.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_y     <= {WINDOW_LOG2{1'b0}};
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (clear) begin
         r_y     <= {WINDOW_LOG2{1'b0}};
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (w_win_done) begin
         r_y     <= w_sat;
         r_valid <= 1'b1;
         // Overwriting an estimate the consumer has not taken.
         if (r_valid && !y_ready) begin
            r_ovr <= 1'b1;
         end
      end else if (r_valid && y_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stoch_bitstream_decoder.sv
module tb_stoch_bitstream_decoder;

   localparam int WL = 4;
   localparam int WU = 2;
   localparam int N  = 16;

   logic          CLK     = 1'b0;
   logic          nRST    = 1'b1;
   logic          en      = 1'b0;
   logic          a       = 1'b0;
   logic          clear   = 1'b0;
   logic          y_ready = 1'b0;
   logic [WL-1:0] y;
   logic          y_valid;
   logic          overrun;

   stoch_bitstream_decoder #(
      .WINDOW_LOG2   (WL),
      .WARMUP_CYCLES (WU)
   ) dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .en      (en),
      .a       (a),
      .clear   (clear),
      .y       (y),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .overrun (overrun)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: enabled-sample index since restart, ones in window.
   int m_n     = 0;
   int m_ones  = 0;
   int m_y     = 0;
   bit m_valid = 1'b0;
   bit m_ovr   = 1'b0;
   int q[$];
   int cyc     = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      m_n     = 0;
      m_ones  = 0;
      m_y     = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      q.delete();
   endfunction

   function automatic bit will_cmp();
      return (m_n >= WU) && (((m_n - WU) % N) == (N - 1));
   endfunction

   function automatic void m_step(input bit e, input bit av, input bit c, input bit r);
      bit xfer;
      bit done;
      int v;
      done = 1'b0;
      if (c) begin
         m_reset();
      end else begin
         xfer = m_valid && r;
         if (e) begin
            if (m_n >= WU) begin
               m_ones += int'(av);
               if (((m_n - WU) % N) == (N - 1)) begin
                  done = 1'b1;
               end
            end
            m_n++;
         end
         if (done) begin
            v = (m_ones > N - 1) ? N - 1 : m_ones;
            m_ones = 0;
            if (m_valid && !xfer) begin
               m_ovr = 1'b1;
               if (q.size() > 0) void'(q.pop_back());
            end
            q.push_back(v);
            m_y     = v;
            m_valid = 1'b1;
         end else if (xfer) begin
            m_valid = 1'b0;
         end
      end
   endfunction

   // Drive one clock's worth of inputs, then advance the model past that edge.
   task automatic step(input bit e, input bit av, input bit c, input bit r);
      en      = e;
      a       = av;
      clear   = c;
      y_ready = r;
      @(posedge CLK);
      #1;
      m_step(e, av, c, r);
      cyc++;
   endtask

   task automatic do_reset(input string label);
      en      = 1'b0;
      a       = 1'b0;
      clear   = 1'b0;
      y_ready = 1'b0;
      nRST    = 1'b0;
      m_reset();
      #1;
      chk({label, "_rst_y"},       int'(y),       0);
      chk({label, "_rst_valid"},   int'(y_valid), 0);
      chk({label, "_rst_overrun"}, int'(overrun), 0);
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      cyc  = 1;
   endtask

   // After a restart, 2 warmup + 16 window samples; estimate only after the 18th.
   task automatic fresh_window(input string label);
      int ones;
      bit av;
      ones = 0;
      for (int i = 0; i < WU + N; i++) begin
         av = 1'($urandom_range(0, 1));
         step(1'b1, av, 1'b0, 1'b0);
         if (i >= WU) ones += int'(av);
         if (i == WU + N - 2) chk({label, "_early_valid"}, int'(y_valid), 0);
      end
      chk({label, "_valid"}, int'(y_valid), 1);
      chk({label, "_y"}, int'(y), (ones > N - 1) ? N - 1 : ones);
   endtask

   // Monitor: compares outputs to the model and pops the scoreboard on transfers.
   initial begin
      forever begin
         @(negedge CLK);
         chk("y_valid", int'(y_valid), int'(m_valid));
         chk("overrun", int'(overrun), int'(m_ovr));
         chk("y_hold",  int'(y),       m_y);
         if (nRST && y_valid && y_ready && !clear) begin
            if (q.size() == 0) chk("xfer_queue_nonempty", 0, 1);
            else chk("y_xfer", int'(y), q.pop_front());
         end
      end
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses[$];
      int first;
      bit av;
      int guard;

      #1;
      do_reset("s1");

      // Constant ones, ready always: first estimate in cycle 19, then every 16.
      first = -1;
      for (int i = 0; i < WU + 4 * N; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b1);
         if (y_valid) begin
            pulses.push_back(cyc);
            if (first < 0) first = cyc;
         end
      end
      chk("s1_first_cycle", first, 19);
      chk("s1_y_sat", int'(y), N - 1);
      chk("s1_npulse", pulses.size(), 4);
      for (int i = 1; i < pulses.size(); i++) chk("s1_period", pulses[i] - pulses[i-1], N);

      // Alternating pattern: 8 ones per window, no overrun.
      for (int i = 0; i < 3 * N; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b1);
      chk("s2_y", int'(y), 8);
      chk("s2_overrun", int'(overrun), 0);

      // en toggling: window spans 32 clocks.
      pulses.delete();
      for (int i = 0; i < 4 * 2 * N + 10; i++) begin
         step(1'((i % 2) == 0), 1'b1, 1'b0, 1'b1);
         if (y_valid) pulses.push_back(cyc);
      end
      chk("s3_npulse_ge3", int'(pulses.size() >= 3), 1);
      for (int i = 1; i < pulses.size(); i++) chk("s3_period", pulses[i] - pulses[i-1], 2 * N);
      chk("s3_y", int'(y), N - 1);

      // Two completions without ready: overwrite and overrun.
      step(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      chk("s4_valid", int'(y_valid), 1);
      chk("s4_overrun", int'(overrun), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("s4_valid_after_xfer", int'(y_valid), 0);
      chk("s4_overrun_sticky", int'(overrun), 1);

      // Ready exactly in the completion cycle of the next window.
      step(1'b1, 1'b0, 1'b1, 1'b0);
      guard = 0;
      while (!m_valid && guard < 40) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         guard++;
      end
      chk("s5_first_valid", int'(y_valid), 1);
      guard = 0;
      while (guard < 40) begin
         av = 1'($urandom_range(0, 1));
         if (will_cmp()) begin
            step(1'b1, av, 1'b0, 1'b1);
            guard = 100;
         end else begin
            step(1'b1, av, 1'b0, 1'b0);
            guard++;
         end
      end
      chk("s5_hit_completion", guard, 100);
      chk("s5_valid", int'(y_valid), 1);
      chk("s5_overrun", int'(overrun), 0);

      // Clear mid-window with a pending estimate; the clear cycle's sample is dropped.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("s6_pre_valid", int'(y_valid), 1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("s6_clr_y", int'(y), 0);
      chk("s6_clr_valid", int'(y_valid), 0);
      chk("s6_clr_overrun", int'(overrun), 0);
      fresh_window("s6");

      // Reset mid-window.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      do_reset("s7");
      fresh_window("s7");

      // Random traffic with occasional clear.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
      end

      en      = 1'b0;
      clear   = 1'b0;
      y_ready = 1'b0;
      @(negedge CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
